// File: rtl/acc_result_streamer_if.sv
// Stream bundle around the result streamer: 32-bit accumulator input side
// and 16-bit requantized output side with TLAST framing.
interface acc_result_streamer_if;
    logic [31:0] acc_TDATA;
    logic        acc_TVALID;
    logic        acc_TREADY;
    logic [15:0] o_TDATA;
    logic        o_TVALID;
    logic        o_TREADY;
    logic        o_TLAST;

    // Streamer view: sinks the accumulator stream, sources the output stream.
    modport slave (
        input  acc_TDATA,
        input  acc_TVALID,
        output acc_TREADY,
        output o_TDATA,
        output o_TVALID,
        input  o_TREADY,
        output o_TLAST
    );

    // Environment view: sources the accumulator stream, sinks the output stream.
    modport master (
        output acc_TDATA,
        output acc_TVALID,
        input  acc_TREADY,
        input  o_TDATA,
        input  o_TVALID,
        output o_TREADY,
        input  o_TLAST
    );
endinterface

// File: rtl/acc_result_streamer.sv
// Requantizes 32-bit accumulator results to 16 bits (shift, round-half-up,
// unsigned saturation) and streams them out through a 2-entry FWFT buffer
// with TLAST framing every FRAME_LEN beats.
module acc_result_streamer #(
    parameter int unsigned SHIFT     = 8,
    parameter int unsigned FRAME_LEN = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    acc_result_streamer_if.slave        bus,
    output logic [15:0]                 sat_count
);

    localparam int unsigned IN_W  = 32;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned SUM_W = IN_W + 1;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned OCC_W = 2;

    // Half an output LSB; (1 << SHIFT) >> 1 collapses to zero when SHIFT is 0.
    localparam logic [SUM_W-1:0] RND       = (SUM_W'(1) << SHIFT) >> 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(2);
    localparam logic [OUT_W-1:0] SAT_MAX   = '1;

    // Stage register S
    logic             s_valid, s_valid_n;
    logic [OUT_W-1:0] s_data,  s_data_n;

    // Output FIFO: h0 is always the head, h1 the second entry
    logic [OUT_W-1:0] h0, h0_n;
    logic [OUT_W-1:0] h1, h1_n;
    logic [OCC_W-1:0] fifo_cnt, fifo_cnt_n;

    // Framing, statistics and registered handshake outputs
    logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
    logic [OUT_W-1:0] sat_cnt_n;
    logic             rdy_q, rdy_n;
    logic             vld_q, vld_n;
    logic             last_q, last_n;

    // Requantize datapath and handshake strobes
    logic [SUM_W-1:0] sum_c;
    logic [SUM_W-1:0] shr_c;
    logic             sat_c;
    logic [OUT_W-1:0] q_c;
    logic             accept_c;
    logic             push_c;
    logic             pop_c;

    // Round, shift and saturate the incoming result; the add is 33 bits so it never wraps
    always_comb begin
        sum_c = {1'b0, bus.acc_TDATA} + RND;
        shr_c = sum_c >> SHIFT;
        sat_c = |shr_c[SUM_W-1:OUT_W];
        q_c   = sat_c ? SAT_MAX : shr_c[OUT_W-1:0];
    end

    // Handshake strobes; S drains only into a non-full FIFO
    always_comb begin
        accept_c = bus.acc_TVALID && bus.acc_TREADY;
        push_c   = s_valid && (fifo_cnt != OCC_FULL);
        pop_c    = vld_q && bus.o_TREADY;
    end

    // Next-state for S, FIFO, beat counter, saturation counter and registered outputs
    always_comb begin
        s_valid_n  = s_valid;
        s_data_n   = s_data;
        h0_n       = h0;
        h1_n       = h1;
        fifo_cnt_n = fifo_cnt;
        beat_cnt_n = beat_cnt;
        sat_cnt_n  = sat_count;

        if (pop_c) begin
            if (fifo_cnt == OCC_FULL) begin
                h0_n = h1;
            end
            fifo_cnt_n = fifo_cnt - OCC_W'(1);
            beat_cnt_n = last_q ? '0 : beat_cnt + CNT_W'(1);
        end

        if (push_c) begin
            if (fifo_cnt_n == '0) begin
                h0_n = s_data;
            end else begin
                h1_n = s_data;
            end
            fifo_cnt_n = fifo_cnt_n + OCC_W'(1);
            s_valid_n  = 1'b0;
        end

        if (accept_c) begin
            s_valid_n = 1'b1;
            s_data_n  = q_c;
            if (sat_c && (sat_count != SAT_MAX)) begin
                sat_cnt_n = sat_count + OUT_W'(1);
            end
        end

        // Ready next cycle when S will be free or able to drain into the FIFO
        rdy_n  = !s_valid_n || (fifo_cnt_n != OCC_FULL);
        vld_n  = (fifo_cnt_n != '0);
        last_n = vld_n && (beat_cnt_n == LAST_BEAT);
    end

    // State registers with synchronous reset; pipeline empty means ready
    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid   <= 1'b0;
            s_data    <= '0;
            h0        <= '0;
            h1        <= '0;
            fifo_cnt  <= '0;
            beat_cnt  <= '0;
            sat_count <= '0;
            rdy_q     <= 1'b1;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            s_valid   <= s_valid_n;
            s_data    <= s_data_n;
            h0        <= h0_n;
            h1        <= h1_n;
            fifo_cnt  <= fifo_cnt_n;
            beat_cnt  <= beat_cnt_n;
            sat_count <= sat_cnt_n;
            rdy_q     <= rdy_n;
            vld_q     <= vld_n;
            last_q    <= last_n;
        end
    end

    // Output stream comes straight from registers; ready is held low during reset
    assign bus.o_TDATA    = h0;
    assign bus.o_TVALID   = vld_q;
    assign bus.o_TLAST    = last_q;
    assign bus.acc_TREADY = rdy_q && !reset;

endmodule

// File: tb/tb_acc_result_streamer.sv
// Directed bench: two instances (SHIFT=8/FRAME_LEN=4 and SHIFT=0/FRAME_LEN=1)
// share one input stream; expected values are hand-computed.
module tb_acc_result_streamer;

    logic        clk;
    logic        reset;
    logic [31:0] acc_data;
    logic        acc_valid;
    logic        o_ready;
    logic [15:0] sat_a;
    logic [15:0] sat_b;

    int total;
    int bad;

    acc_result_streamer_if ifa ();
    acc_result_streamer_if ifb ();

    assign ifa.acc_TDATA  = acc_data;
    assign ifa.acc_TVALID = acc_valid;
    assign ifa.o_TREADY   = o_ready;
    assign ifb.acc_TDATA  = acc_data;
    assign ifb.acc_TVALID = acc_valid;
    assign ifb.o_TREADY   = o_ready;

    acc_result_streamer #(.SHIFT(8), .FRAME_LEN(4)) u_a (
        .clk       (clk),
        .reset     (reset),
        .bus       (ifa),
        .sat_count (sat_a)
    );

    acc_result_streamer #(.SHIFT(0), .FRAME_LEN(1)) u_b (
        .clk       (clk),
        .reset     (reset),
        .bus       (ifb),
        .sat_count (sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    beat_t qa[$];

    typedef struct {
        logic [31:0] din;
        logic [15:0] ea;
        logic [15:0] eb;
        logic        sa;
        logic        sb;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitor on DUT A: records handshakes and checks stall stability
    logic        stall_a;
    logic [15:0] stall_d;
    initial begin
        stall_a = 1'b0;
        stall_d = '0;
    end
    always @(negedge clk) begin
        if (reset) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) begin
                chk("stall_valid", 32'(ifa.o_TVALID), 32'd1);
                chk("stall_data", 32'(ifa.o_TDATA), 32'(stall_d));
            end
            if (ifa.o_TVALID && o_ready) begin
                qa.push_back('{d: ifa.o_TDATA, l: ifa.o_TLAST});
            end
            stall_a = ifa.o_TVALID && !o_ready;
            stall_d = ifa.o_TDATA;
        end
    end

    task automatic send(input logic [31:0] d);
        int n;
        n = 0;
        acc_data  = d;
        acc_valid = 1'b1;
        @(negedge clk);
        while (!ifa.acc_TREADY && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("send_timeout", 32'(n), 32'd0);
        end
        @(posedge clk);
        #1;
        acc_valid = 1'b0;
    endtask

    task automatic do_reset();
        acc_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready_low", 32'(ifa.acc_TREADY), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        qa.delete();
    endtask

    task automatic wait_beats(input int n);
        int c;
        c = 0;
        while (qa.size() < n && c < 300) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
        chk("beat_count", 32'(qa.size()), 32'(n));
    endtask

    // Compare recorded beats against k+1 with TLAST on every 4th beat
    task automatic check_seq(input string name, input int n);
        for (int k = 0; k < n; k++) begin
            if (k < qa.size()) begin
                chk({name, "_data"}, 32'(qa[k].d), 32'(k + 1));
                chk({name, "_last"}, 32'(qa[k].l), 32'((k % 4) == 3));
            end
        end
    endtask

    logic [15:0] exp_sa;
    logic [15:0] exp_sb;

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        acc_valid = 1'b0;
        acc_data  = '0;
        o_ready   = 1'b1;

        tbl[0] = '{32'h00001280, 16'h0013, 16'h1280, 1'b0, 1'b0};
        tbl[1] = '{32'h0000017F, 16'h0001, 16'h017F, 1'b0, 1'b0};
        tbl[2] = '{32'h00000180, 16'h0002, 16'h0180, 1'b0, 1'b0};
        tbl[3] = '{32'h0000ABCD, 16'h00AC, 16'hABCD, 1'b0, 1'b0};
        tbl[4] = '{32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
        tbl[5] = '{32'h00FFFF80, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
        tbl[6] = '{32'h00FFFF7F, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1};
        tbl[7] = '{32'h00000000, 16'h0000, 16'h0000, 1'b0, 1'b0};
        tbl[8] = '{32'h0000007F, 16'h0000, 16'h007F, 1'b0, 1'b0};
        tbl[9] = '{32'h00000080, 16'h0001, 16'h0080, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("init_ready_in_reset", 32'(ifa.acc_TREADY), 32'd0);
        reset = 1'b0;
        #1;
        chk("init_valid", 32'(ifa.o_TVALID), 32'd0);
        chk("init_data", 32'(ifa.o_TDATA), 32'd0);
        chk("init_last", 32'(ifa.o_TLAST), 32'd0);
        chk("init_sat", 32'(sat_a), 32'd0);
        chk("init_ready", 32'(ifa.acc_TREADY), 32'd1);

        // Table: requantize, latency, framing on both instances
        exp_sa = '0;
        exp_sb = '0;
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].din);
            chk("lat_early_valid", 32'(ifa.o_TVALID), 32'd0);
            if (tbl[i].sa) exp_sa = exp_sa + 16'd1;
            if (tbl[i].sb) exp_sb = exp_sb + 16'd1;
            @(posedge clk);
            #1;
            chk("vec_valid_a", 32'(ifa.o_TVALID), 32'd1);
            chk("vec_data_a", 32'(ifa.o_TDATA), 32'(tbl[i].ea));
            chk("vec_last_a", 32'(ifa.o_TLAST), 32'((i % 4) == 3));
            chk("vec_data_b", 32'(ifb.o_TDATA), 32'(tbl[i].eb));
            chk("vec_last_b", 32'(ifb.o_TLAST), 32'd1);
            chk("vec_sat_a", 32'(sat_a), 32'(exp_sa));
            chk("vec_sat_b", 32'(sat_b), 32'(exp_sb));
            @(posedge clk);
            #1;
        end
        chk("sat_final_a", 32'(sat_a), 32'd2);

        // Backpressure: three beats fill S and the FIFO, then input stalls
        do_reset();
        o_ready = 1'b0;
        for (int k = 1; k <= 3; k++) send(32'(k * 256));
        chk("bp_ready_low", 32'(ifa.acc_TREADY), 32'd0);
        chk("bp_head", 32'(ifa.o_TDATA), 32'h0001);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_ready_still_low", 32'(ifa.acc_TREADY), 32'd0);
        chk("bp_head_held", 32'(ifa.o_TDATA), 32'h0001);
        o_ready = 1'b1;
        for (int k = 4; k <= 10; k++) send(32'(k * 256));
        wait_beats(10);
        check_seq("bp", 10);

        // Backpressure with random downstream ready
        do_reset();
        fork
            begin
                for (int k = 1; k <= 10; k++) send(32'(k * 256));
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    o_ready = 1'($urandom_range(0, 1));
                end
                o_ready = 1'b1;
            end
        join
        wait_beats(10);
        check_seq("rnd", 10);

        // Framing: nine beats, TLAST on beats 4 and 8 only
        do_reset();
        o_ready = 1'b1;
        for (int k = 1; k <= 9; k++) send(32'(k * 256));
        wait_beats(9);
        check_seq("frm", 9);

        // Reset mid-operation discards S and FIFO contents
        do_reset();
        o_ready = 1'b0;
        send(32'hFFFFFFFF);
        send(32'h00000200);
        send(32'h00000300);
        chk("mid_sat_before", 32'(sat_a), 32'd1);
        chk("mid_ready_full", 32'(ifa.acc_TREADY), 32'd0);
        reset = 1'b1;
        #1;
        chk("mid_ready_in_reset", 32'(ifa.acc_TREADY), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        qa.delete();
        #1;
        chk("mid_valid", 32'(ifa.o_TVALID), 32'd0);
        chk("mid_sat", 32'(sat_a), 32'd0);
        chk("mid_last", 32'(ifa.o_TLAST), 32'd0);
        chk("mid_ready_after", 32'(ifa.acc_TREADY), 32'd1);
        o_ready = 1'b1;
        for (int k = 1; k <= 4; k++) send(32'(k * 256));
        wait_beats(4);
        check_seq("mid", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
